multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory phases end on mem_ready; 0 = memory phases end after MEM_LAT cycles.
REQ-002 Parameter MEM_LAT, default 2, meaning: fixed memory latency in cycles (>=1), used only when MEM_HANDSHAKE=0.
REQ-003 Parameter TIMEOUT, default 16, meaning: maximum cycles in one memory phase before timeout trap.
REQ-004 Parameter CNT_W, default 32, meaning: width of the retired-instruction counter.
REQ-005 One clock; reset is asynchronous and active-high; ports clk and rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 opcode  in  7  instruction[6:0] from the external instruction register, valid from DECODE onward.
REQ-009 mem_ready  in  1  memory completion strobe.
REQ-010 alu_src, branch, mem_read, mem_write, reg_write  out  1 each  datapath controls, per-opcode meanings unchanged from the single-cycle decoder.
REQ-011 mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4 (jal), 11 PC+4 (jalr).
REQ-012 pc_write, ir_write, iord, mem_req  out  1 each  PC load, IR load, data-address select, memory request.
REQ-013 retire  out  1  one-cycle pulse per completed instruction.
REQ-014 retired  out  CNT_W  count of retired instructions.
REQ-015 trap, trap_cause  out  1, 1  sticky fault; cause 0 illegal opcode, 1 timeout.
REQ-016 state  out  3  current state encoding for debug.

Function
REQ-017 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; encodings 6-7 unreachable and return to FETCH.
REQ-018 FETCH: mem_req=1, mem_read=1, iord=0; on phase end assert ir_write and pc_write for that cycle, then go to DECODE.
REQ-019 DECODE: latch opcode into op_q; go to EXEC if legal, else TRAP with cause 0.
REQ-020 Legal opcodes: 0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc; all others illegal.
REQ-021 EXEC controls from op_q: alu_src=1 for I, load, store, jalr, lui, auipc; branch=1 for branch, jal, jalr; pc_write=1 for jal and jalr.
REQ-022 EXEC next state: load/store -> MEM; branch -> FETCH with retire; all others -> WB.
REQ-023 MEM: mem_req=1, iord=1, and mem_read=1 (load) or mem_write=1 (store); on phase end load -> WB, store -> FETCH with retire.
REQ-024 WB: reg_write=1 for exactly one cycle; mem_to_reg per REQ-011, with 00 for R, I, lui and auipc; then -> FETCH with retire.
REQ-025 Outputs are decoded from state and op_q only; every control not named for a state is 0, and mem_to_reg is 00 outside WB (no X values).
REQ-026 Phase end: MEM_HANDSHAKE=1 -> the cycle mem_ready is sampled 1, so the minimum phase is 1 cycle; MEM_HANDSHAKE=0 -> the MEM_LAT-th cycle of the phase, with mem_ready ignored.
REQ-027 Wait counter clears on phase entry; if TIMEOUT cycles pass without phase end, go to TRAP with cause 1; a phase ending on cycle TIMEOUT exactly is not a timeout.
REQ-028 Simultaneous mem_ready and timeout on the same cycle: completion wins.
REQ-029 TRAP: trap=1 and all other controls 0; TRAP holds until rst.
REQ-030 retire pulses in the cycle of the transition into FETCH; retired increments on the same edge and wraps modulo 2^CNT_W.

Reset
REQ-031 rst asserted at any time, including mid-memory-phase: state=FETCH, op_q=0, wait counter=0, retired=0, trap=0, trap_cause=0.
REQ-032 While rst=1, all outputs are 0, including mem_req.
REQ-033 The first FETCH begins on the first rising edge after rst deasserts.

Verification
REQ-034 MEM_HANDSHAKE=1, mem_ready tied 1, opcode 0110011 -> states 0,1,2,4,0; reg_write=1 only in cycle 4; retire at cycle 4; retired=1.
REQ-035 Load 0000011, ready=1 -> 5 cycles; MEM has mem_read=1, iord=1; WB has mem_to_reg=01. Store 0100011 -> 4 cycles, mem_write=1 in MEM, reg_write never 1.
REQ-036 jal 1101111 -> pc_write=1 in EXEC, mem_to_reg=10 in WB. Branch 1100011 -> 3 cycles, no reg_write.
REQ-037 Opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=0, all controls 0 for 20 further cycles; then rst -> FETCH.
REQ-038 mem_ready held 0 in FETCH with TIMEOUT=16 -> TRAP on cycle 17 with trap_cause=1; mem_ready=1 on cycle 16 -> normal completion.
REQ-039 MEM_HANDSHAKE=0, MEM_LAT=3, load -> FETCH and MEM each last 3 cycles regardless of mem_ready; assert rst in MEM cycle 2 -> all outputs 0 immediately, retired=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle FSM control unit: fetch/decode/exec/mem/writeback sequencing with memory-phase
// timeout trapping and a retired-instruction counter.
module multicycle_control #(
   parameter int unsigned MEM_HANDSHAKE = 1,
   parameter int unsigned MEM_LAT       = 2,
   parameter int unsigned TIMEOUT       = 16,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             alu_src,
   output logic             branch,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       mem_to_reg,
   output logic             pc_write,
   output logic             ir_write,
   output logic             iord,
   output logic             mem_req,
   output logic             retire,
   output logic [CNT_W-1:0] retired,
   output logic             trap,
   output logic             trap_cause,
   output logic [2:0]       state
);

   localparam logic [2:0] StFetch  = 3'd0;
   localparam logic [2:0] StDecode = 3'd1;
   localparam logic [2:0] StExec   = 3'd2;
   localparam logic [2:0] StMem    = 3'd3;
   localparam logic [2:0] StWb     = 3'd4;
   localparam logic [2:0] StTrap   = 3'd5;

   localparam logic [6:0] OpR     = 7'b0110011;
   localparam logic [6:0] OpI     = 7'b0010011;
   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpBr    = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;
   localparam logic [6:0] OpJalr  = 7'b1100111;
   localparam logic [6:0] OpLui   = 7'b0110111;
   localparam logic [6:0] OpAuipc = 7'b0010111;

   localparam int unsigned WAIT_W = $clog2(TIMEOUT + MEM_LAT + 1);

   logic [2:0]        state_q, state_d;
   logic [6:0]        op_q, op_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  retired_q;
   logic              trap_cause_q, trap_cause_d;
   logic              run_q;
   logic              in_phase, phase_end, timed_out, to_fetch;
   logic              is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;

   function automatic logic legal_op(input logic [6:0] op);
      case (op)
         OpR, OpI, OpLoad, OpStore, OpBr, OpJal, OpJalr, OpLui, OpAuipc: legal_op = 1'b1;
         default:                                                       legal_op = 1'b0;
      endcase
   endfunction

   assign is_i     = (op_q == OpI);
   assign is_ld    = (op_q == OpLoad);
   assign is_st    = (op_q == OpStore);
   assign is_br    = (op_q == OpBr);
   assign is_jal   = (op_q == OpJal);
   assign is_jalr  = (op_q == OpJalr);
   assign is_lui   = (op_q == OpLui);
   assign is_auipc = (op_q == OpAuipc);

   // run_q holds everything idle until the first edge after reset release.
   assign in_phase = run_q && ((state_q == StFetch) || (state_q == StMem));

   always_comb begin
      phase_end = 1'b0;
      if (in_phase) begin
         if (MEM_HANDSHAKE != 0) phase_end = mem_ready;
         else                    phase_end = (wait_q == WAIT_W'(MEM_LAT - 1));
      end
   end

   // Completion has priority over timeout in the same cycle.
   assign timed_out = in_phase && !phase_end && (wait_q == WAIT_W'(TIMEOUT - 1));

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      wait_d       = '0;
      trap_cause_d = trap_cause_q;
      to_fetch     = 1'b0;
      if (run_q) begin
         case (state_q)
            StFetch: begin
               if (phase_end) begin
                  state_d = StDecode;
               end else if (timed_out) begin
                  state_d      = StTrap;
                  trap_cause_d = 1'b1;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            StDecode: begin
               op_d = opcode;
               if (legal_op(opcode)) begin
                  state_d = StExec;
               end else begin
                  state_d      = StTrap;
                  trap_cause_d = 1'b0;
               end
            end
            StExec: begin
               if (is_ld || is_st) begin
                  state_d = StMem;
               end else if (is_br) begin
                  state_d  = StFetch;
                  to_fetch = 1'b1;
               end else begin
                  state_d = StWb;
               end
            end
            StMem: begin
               if (phase_end) begin
                  if (is_ld) begin
                     state_d = StWb;
                  end else begin
                     state_d  = StFetch;
                     to_fetch = 1'b1;
                  end
               end else if (timed_out) begin
                  state_d      = StTrap;
                  trap_cause_d = 1'b1;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            StWb: begin
               state_d  = StFetch;
               to_fetch = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StFetch;
         op_q         <= '0;
         wait_q       <= '0;
         retired_q    <= '0;
         trap_cause_q <= 1'b0;
         run_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         wait_q       <= wait_d;
         trap_cause_q <= trap_cause_d;
         run_q        <= 1'b1;
         if (to_fetch) retired_q <= retired_q + 1'b1;
      end
   end

   always_comb begin
      alu_src    = 1'b0;
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 2'b00;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_req    = 1'b0;
      trap       = 1'b0;
      retire     = to_fetch;
      retired    = retired_q;
      trap_cause = trap_cause_q;
      state      = state_q;
      if (run_q) begin
         case (state_q)
            StFetch: begin
               mem_req  = 1'b1;
               mem_read = 1'b1;
               ir_write = phase_end;
               pc_write = phase_end;
            end
            StExec: begin
               alu_src  = is_i | is_ld | is_st | is_jalr | is_lui | is_auipc;
               branch   = is_br | is_jal | is_jalr;
               pc_write = is_jal | is_jalr;
            end
            StMem: begin
               mem_req   = 1'b1;
               iord      = 1'b1;
               mem_read  = is_ld;
               mem_write = is_st;
            end
            StWb: begin
               reg_write = 1'b1;
               if (is_ld)        mem_to_reg = 2'b01;
               else if (is_jal)  mem_to_reg = 2'b10;
               else if (is_jalr) mem_to_reg = 2'b11;
               else              mem_to_reg = 2'b00;
            end
            StTrap:  trap = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a handshake instance and a fixed-latency instance
// run side by side, the selected one checked cycle by cycle against a per-instruction model.
module tb_multicycle_control;

   localparam int unsigned TO  = 16;
   localparam int unsigned LAT = 3;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // Observation vector bit positions.
   localparam int B_ALU = 16, B_BR = 15, B_RD = 14, B_WR = 13, B_RW = 12, B_M2R = 10;
   localparam int B_PCW = 9, B_IRW = 8, B_IORD = 7, B_REQ = 6, B_RET = 5, B_TRAP = 4;
   localparam int B_CAUSE = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode;
   logic        mem_ready;
   logic [16:0] vec_a, vec_b;
   logic [31:0] ret_a;
   logic [3:0]  ret_b;
   logic        mode;
   int unsigned cnt;
   int          checks = 0;
   int          failures = 0;
   logic [6:0]  ops [9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

   always #5 clk = ~clk;

   multicycle_control #(.MEM_HANDSHAKE(1), .MEM_LAT(2), .TIMEOUT(TO), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .alu_src(vec_a[16]), .branch(vec_a[15]), .mem_read(vec_a[14]), .mem_write(vec_a[13]),
      .reg_write(vec_a[12]), .mem_to_reg(vec_a[11:10]), .pc_write(vec_a[9]),
      .ir_write(vec_a[8]), .iord(vec_a[7]), .mem_req(vec_a[6]), .retire(vec_a[5]),
      .retired(ret_a), .trap(vec_a[4]), .trap_cause(vec_a[3]), .state(vec_a[2:0])
   );

   multicycle_control #(.MEM_HANDSHAKE(0), .MEM_LAT(LAT), .TIMEOUT(TO), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .alu_src(vec_b[16]), .branch(vec_b[15]), .mem_read(vec_b[14]), .mem_write(vec_b[13]),
      .reg_write(vec_b[12]), .mem_to_reg(vec_b[11:10]), .pc_write(vec_b[9]),
      .ir_write(vec_b[8]), .iord(vec_b[7]), .mem_req(vec_b[6]), .retire(vec_b[5]),
      .retired(ret_b), .trap(vec_b[4]), .trap_cause(vec_b[3]), .state(vec_b[2:0])
   );

   logic [16:0] obs_vec;
   logic [31:0] obs_ret;
   assign obs_vec = mode ? vec_b : vec_a;
   assign obs_ret = mode ? 32'(ret_b) : ret_a;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_cnt();
      return mode ? (cnt & 32'hf) : cnt;
   endfunction

   function automatic logic [6:0] rand_op();
      return 7'($urandom_range(0, 127));
   endfunction

   // One clock cycle: drive inputs after the falling edge, then compare.
   task automatic step(input string tag, input logic [16:0] exp, input logic rdy,
                       input logic [6:0] op);
      @(negedge clk);
      mem_ready = rdy;
      opcode    = op;
      #1;
      check(tag, 32'(obs_vec), 32'(exp));
      check({tag, "_retired"}, obs_ret, exp_cnt());
      if (exp[B_RET]) cnt++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      opcode    = rand_op();
      #1;
      cnt = 0;
      check("in_reset", 32'(obs_vec), 32'd0);
      check("in_reset_retired", obs_ret, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = 1'b1;
      #1;
      check("release", 32'(obs_vec), 32'd0);
   endtask

   task automatic trap_hold(input logic cause, input int n);
      logic [16:0] e;
      e = '0;
      e[2:0]    = 3'd5;
      e[B_TRAP] = 1'b1;
      e[B_CAUSE] = cause;
      for (int i = 0; i < n; i++) step("trap", e, 1'($urandom_range(0, 1)), rand_op());
   endtask

   // Memory phase; force_at=0 gives random ready, else ready only on that cycle.
   task automatic phase(input logic is_fetch, input logic [6:0] op, input int force_at,
                        input int abort_at, output logic timed, output logic aborted);
      logic done;
      done    = 1'b0;
      aborted = 1'b0;
      for (int w = 1; w <= int'(TO) && !done && !aborted; w++) begin
         logic rdy, fin;
         logic [16:0] e;
         rdy = (force_at == 0) ? ($urandom_range(0, 2) == 0) : (w == force_at);
         fin = mode ? (w == int'(LAT)) : rdy;
         e = '0;
         e[B_REQ] = 1'b1;
         if (is_fetch) begin
            e[2:0]  = 3'd0;
            e[B_RD] = 1'b1;
            e[B_IRW] = fin;
            e[B_PCW] = fin;
         end else begin
            e[2:0]   = 3'd3;
            e[B_IORD] = 1'b1;
            e[B_RD]  = (op == OP_LD);
            e[B_WR]  = (op == OP_ST);
            e[B_RET] = fin && (op == OP_ST);
         end
         step(is_fetch ? "fetch" : "mem", e, rdy, rand_op());
         if (w == abort_at) begin
            #1 rst = 1'b1;
            #1;
            check("abort", 32'(obs_vec), 32'd0);
            check("abort_retired", obs_ret, 32'd0);
            cnt = 0;
            aborted = 1'b1;
         end
         done = fin;
      end
      timed = !done && !aborted;
   endtask

   // Returns stop=1 when the DUT has trapped or been reset and needs a fresh reset.
   task automatic run_instr(input logic [6:0] op, input int f_at, input int m_at,
                            input int abort_at, output logic stop);
      logic timed, aborted, legal;
      logic [16:0] e;
      stop = 1'b1;
      legal = 1'b0;
      foreach (ops[k]) if (ops[k] == op) legal = 1'b1;
      phase(1'b1, op, f_at, 0, timed, aborted);
      if (timed) begin
         trap_hold(1'b1, 3);
         return;
      end
      e = '0;
      e[2:0] = 3'd1;
      step("decode", e, 1'($urandom_range(0, 1)), op);
      if (!legal) begin
         trap_hold(1'b0, 3);
         return;
      end
      e = '0;
      e[2:0]  = 3'd2;
      e[B_ALU] = (op == OP_I) || (op == OP_LD) || (op == OP_ST) || (op == OP_JALR) ||
                 (op == OP_LUI) || (op == OP_AUIPC);
      e[B_BR]  = (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
      e[B_PCW] = (op == OP_JAL) || (op == OP_JALR);
      e[B_RET] = (op == OP_BR);
      step("exec", e, 1'($urandom_range(0, 1)), rand_op());
      if (op == OP_BR) begin
         stop = 1'b0;
         return;
      end
      if (op == OP_LD || op == OP_ST) begin
         phase(1'b0, op, m_at, abort_at, timed, aborted);
         if (aborted) return;
         if (timed) begin
            trap_hold(1'b1, 3);
            return;
         end
         if (op == OP_ST) begin
            stop = 1'b0;
            return;
         end
      end
      e = '0;
      e[2:0]   = 3'd4;
      e[B_RW]  = 1'b1;
      e[B_RET] = 1'b1;
      e[11:10] = (op == OP_LD) ? 2'b01 : (op == OP_JAL) ? 2'b10 : (op == OP_JALR) ? 2'b11 : 2'b00;
      step("wb", e, 1'($urandom_range(0, 1)), rand_op());
      stop = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic stop;
      rst = 1'b1;
      mem_ready = 1'b0;
      opcode = '0;
      mode = 1'b0;
      cnt = 0;
      do_reset();
      // Every opcode with memory always ready.
      foreach (ops[k]) run_instr(ops[k], 1, 1, 0, stop);
      // Illegal opcode traps and holds, then reset recovers.
      run_instr(7'b1111111, 1, 1, 0, stop);
      trap_hold(1'b0, 20);
      do_reset();
      run_instr(OP_R, 1, 1, 0, stop);
      // Fetch timeout, and completion on the last allowed cycle.
      run_instr(OP_R, int'(TO) + 1, 1, 0, stop);
      do_reset();
      run_instr(OP_R, int'(TO), 1, 0, stop);
      run_instr(OP_LD, 1, int'(TO), 0, stop);
      run_instr(OP_ST, 2, int'(TO) + 1, 0, stop);
      do_reset();
      for (int i = 0; i < 60; i++) begin
         logic [6:0] op;
         op = ($urandom_range(0, 9) == 0) ? rand_op() : ops[$urandom_range(0, 8)];
         run_instr(op, 0, 0, 0, stop);
         if (stop) do_reset();
      end
      // Fixed-latency instance, including counter wrap and a mid-MEM reset.
      mode = 1'b1;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         run_instr(ops[$urandom_range(0, 8)], 0, 0, 0, stop);
         if (stop) do_reset();
      end
      run_instr(OP_LD, 0, 0, 2, stop);
      do_reset();
      run_instr(OP_LD, 0, 0, 0, stop);
      run_instr(OP_ST, 0, 0, 0, stop);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
